// File: rtl/seven_seg_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus.
// Rebuilds per-digit segment patterns from the scan, decodes them to hex,
// and flags illegal anode patterns and scan stalls.
module seven_seg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  cathode,
  output logic [6:0]  digit0,
  output logic [6:0]  digit1,
  output logic [6:0]  digit2,
  output logic [6:0]  digit3,
  output logic [15:0] hex,
  output logic [3:0]  hex_valid,
  output logic        frame_done,
  output logic        scan_error,
  output logic        stalled
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state, state_n;
  logic [SET_W-1:0] settle_cnt, settle_n;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       an_s1, an_s2, an_p;
  logic [6:0]       cat_s1, cat_s2, cat_p;
  logic [6:0]       digit_r [4];
  logic [3:0]       seen;
  logic [3:0]       seen_n;
  logic             an_chg, cat_chg, an_blank, an_legal;
  logic [1:0]       an_idx;
  logic             capture, err_set;
  logic [4:0]       dec;

  // Returns {valid, nibble}; unknown patterns decode to {0, 0}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'b0;
    endcase
  endfunction

  // Two-flop input synchronisers plus a one-cycle history for change detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_s1  <= '1;
      an_s2  <= '1;
      an_p   <= '1;
      cat_s1 <= '1;
      cat_s2 <= '1;
      cat_p  <= '1;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      cat_s1 <= cathode;
      cat_s2 <= cat_s1;
      cat_p  <= cat_s2;
    end
  end

  // Classify the synced anode bus: blank, single-digit legal, or illegal.
  always_comb begin
    an_chg   = (an_s2 != an_p);
    cat_chg  = (cat_s2 != cat_p);
    an_blank = (an_s2 == 4'b1111);
    an_legal = 1'b1;
    an_idx   = 2'd0;
    case (an_s2)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_legal = 1'b0;
    endcase
    dec = decode(cat_s2);
  end

  // FSM state and settle counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
    end
  end

  // Next-state logic: settle on a stable legal anode, capture once per dwell.
  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    capture  = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (an_legal) begin
          state_n  = SETTLE;
          settle_n = '0;
        end else if (!an_blank) begin
          err_set = 1'b1;
        end
      end
      SETTLE: begin
        if (an_chg || cat_chg) begin
          settle_n = '0;
          if (!an_legal) begin
            state_n = IDLE;
            err_set = !an_blank;
          end
        end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          capture  = 1'b1;
          state_n  = HOLD;
          settle_n = '0;
        end else begin
          settle_n = settle_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (an_chg) begin
          settle_n = '0;
          if (an_legal) begin
            state_n = SETTLE;
          end else begin
            state_n = IDLE;
            err_set = !an_blank;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign seen_n = seen | (4'b0001 << an_idx);

  // Capture datapath, frame tracking, stall timeout and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) digit_r[i] <= 7'h7F;
      hex        <= '0;
      hex_valid  <= '0;
      frame_done <= 1'b0;
      scan_error <= 1'b0;
      stalled    <= 1'b0;
      seen       <= '0;
      tmo_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (err_set) scan_error <= 1'b1;
      if (capture) begin
        digit_r[an_idx]       <= cat_s2;
        hex[an_idx*4 +: 4]    <= dec[3:0];
        hex_valid[an_idx]     <= dec[4];
        tmo_cnt               <= '0;
        stalled               <= 1'b0;
        if (seen_n == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_n;
        end
      end else if (tmo_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          stalled   <= 1'b1;
          hex_valid <= '0;
          seen      <= '0;
        end
      end
    end
  end

  assign digit0 = digit_r[0];
  assign digit1 = digit_r[1];
  assign digit2 = digit_r[2];
  assign digit3 = digit_r[3];

endmodule
